// File: rtl/lock_pkg.sv
// Shared state encoding and sizing helper for the code_lock block.
package lock_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_PROGRAM  = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter that times the lockout window; done is high at zero.
module lockout_timer
    import lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int TW = width_for(LOCKOUT_CYCLES);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(LOCKOUT_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/code_lock.sv
// Serial binary combination lock with reprogrammable code, failure counting
// and a timed lockout after too many consecutive wrong attempts.
module code_lock
    import lock_pkg::*;
#(
    parameter int                  CODE_SIZE      = 8,
    parameter logic [CODE_SIZE-1:0] DEFAULT_CODE  = 8'b1010_0110,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             b0,
    input  logic                             b1,
    input  logic                             enter,
    input  logic                             relock,
    input  logic                             prog,
    output logic                             locked,
    output logic                             lockout,
    output logic                             programming,
    output logic [CODE_SIZE-1:0]             currentOut,
    output logic [$clog2(CODE_SIZE+1)-1:0]   digitCount,
    output logic [$clog2(MAX_TRIES+1)-1:0]   triesLeft,
    output logic                             ok,
    output logic                             err
);

    localparam int CW  = $clog2(CODE_SIZE + 1);
    localparam int TRW = $clog2(MAX_TRIES + 1);

    state_t               state, state_n;
    logic [CODE_SIZE-1:0] cur, cur_n;
    logic [CODE_SIZE-1:0] stored, stored_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [TRW-1:0]       tries, tries_n;
    logic                 ok_n, err_n;
    logic                 load;
    logic                 timer_done;
    logic                 full;

    assign full = (cnt == CW'(CODE_SIZE));

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (reset),
        .load (load),
        .done (timer_done)
    );

    // One event per cycle: relock > prog > enter > b0 > b1.
    always_comb begin
        state_n  = state;
        cur_n    = cur;
        cnt_n    = cnt;
        tries_n  = tries;
        stored_n = stored;
        ok_n     = 1'b0;
        err_n    = 1'b0;
        load     = 1'b0;
        if (state == ST_LOCKOUT) begin
            if (timer_done) begin
                state_n = ST_LOCKED;
                tries_n = TRW'(MAX_TRIES);
            end
        end else if (relock) begin
            state_n = ST_LOCKED;
            cur_n   = '0;
            cnt_n   = '0;
        end else if (prog) begin
            if (state == ST_UNLOCKED) begin
                state_n = ST_PROGRAM;
                cur_n   = '0;
                cnt_n   = '0;
            end
        end else if (enter) begin
            cur_n = '0;
            cnt_n = '0;
            case (state)
                ST_LOCKED: begin
                    if (full && cur == stored) begin
                        state_n = ST_UNLOCKED;
                        tries_n = TRW'(MAX_TRIES);
                        ok_n    = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                        tries_n = tries - TRW'(1);
                        if (tries == TRW'(1)) begin
                            state_n = ST_LOCKOUT;
                            load    = 1'b1;
                        end
                    end
                end
                ST_PROGRAM: begin
                    if (full) begin
                        stored_n = cur;
                        state_n  = ST_LOCKED;
                        ok_n     = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (b0 || b1) begin
            // b0 outranks b1, so the shifted digit is 1 only when b0 is low.
            if (!full) begin
                cur_n = {cur[CODE_SIZE-2:0], ~b0};
                cnt_n = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LOCKED;
            cur         <= '0;
            cnt         <= '0;
            tries       <= TRW'(MAX_TRIES);
            stored      <= DEFAULT_CODE;
            ok          <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b1;
            lockout     <= 1'b0;
            programming <= 1'b0;
        end else begin
            state       <= state_n;
            cur         <= cur_n;
            cnt         <= cnt_n;
            tries       <= tries_n;
            stored      <= stored_n;
            ok          <= ok_n;
            err         <= err_n;
            locked      <= !(state_n == ST_UNLOCKED || state_n == ST_PROGRAM);
            lockout     <= (state_n == ST_LOCKOUT);
            programming <= (state_n == ST_PROGRAM);
        end
    end

    assign currentOut = cur;
    assign digitCount = cnt;
    assign triesLeft  = tries;

endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock: reference model feeds an expected-output queue that is
// compared each cycle, plus directed checks on the key scenarios.
module tb_code_lock;

    localparam int M_LOCKED   = 0;
    localparam int M_UNLOCKED = 1;
    localparam int M_PROGRAM  = 2;
    localparam int M_LOCKOUT  = 3;
    localparam int W          = 14;

    logic       clk = 1'b0;
    logic       reset;
    logic       b0, b1, enter, relock, prog;
    logic       locked, lockout, programming, ok, err;
    logic [3:0] currentOut;
    logic [2:0] digitCount;
    logic [1:0] triesLeft;

    int n_checks = 0;
    int n_errors = 0;
    int lockout_seen = 0;

    logic [W-1:0] exp_q[$];

    int         m_state;
    logic [3:0] m_cur;
    logic [3:0] m_stored;
    int         m_cnt;
    int         m_fails;
    int         m_timer;
    logic       m_ok, m_err;

    code_lock #(
        .CODE_SIZE      (4),
        .DEFAULT_CODE   (4'b1010),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .b0          (b0),
        .b1          (b1),
        .enter       (enter),
        .relock      (relock),
        .prog        (prog),
        .locked      (locked),
        .lockout     (lockout),
        .programming (programming),
        .currentOut  (currentOut),
        .digitCount  (digitCount),
        .triesLeft   (triesLeft),
        .ok          (ok),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_vec();
        return {locked, lockout, programming, currentOut, digitCount, triesLeft, ok, err};
    endfunction

    function automatic logic [W-1:0] model_vec();
        logic m_locked;
        m_locked = (m_state == M_LOCKED) || (m_state == M_LOCKOUT);
        return {m_locked, m_state == M_LOCKOUT, m_state == M_PROGRAM, m_cur,
                3'(m_cnt), 2'(3 - m_fails), m_ok, m_err};
    endfunction

    task automatic model_reset();
        m_state  = M_LOCKED;
        m_cur    = 4'b0000;
        m_stored = 4'b1010;
        m_cnt    = 0;
        m_fails  = 0;
        m_timer  = 0;
        m_ok     = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic p, input logic e, input logic z, input logic o);
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (m_state == M_LOCKOUT) begin
            if (m_timer == 0) begin
                m_state = M_LOCKED;
                m_fails = 0;
            end else begin
                m_timer--;
            end
        end else if (r) begin
            m_state = M_LOCKED;
            m_cur   = 4'b0000;
            m_cnt   = 0;
        end else if (p) begin
            if (m_state == M_UNLOCKED) begin
                m_state = M_PROGRAM;
                m_cur   = 4'b0000;
                m_cnt   = 0;
            end
        end else if (e) begin
            if (m_state == M_LOCKED) begin
                if (m_cnt == 4 && m_cur == m_stored) begin
                    m_state = M_UNLOCKED;
                    m_fails = 0;
                    m_ok    = 1'b1;
                end else begin
                    m_err = 1'b1;
                    m_fails++;
                    if (m_fails == 3) begin
                        m_state = M_LOCKOUT;
                        m_timer = 7;
                    end
                end
            end else if (m_state == M_PROGRAM) begin
                if (m_cnt == 4) begin
                    m_stored = m_cur;
                    m_state  = M_LOCKED;
                    m_ok     = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_cur = 4'b0000;
            m_cnt = 0;
        end else if (z || o) begin
            if (m_cnt < 4) begin
                m_cur = {m_cur[2:0], (z ? 1'b0 : 1'b1)};
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic cycle(input logic r, input logic p, input logic e, input logic z, input logic o);
        logic [W-1:0] exp_v;
        relock = r;
        prog   = p;
        enter  = e;
        b0     = z;
        b1     = o;
        model_step(r, p, e, z, o);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        relock = 1'b0;
        prog   = 1'b0;
        enter  = 1'b0;
        b0     = 1'b0;
        b1     = 1'b0;
        if (lockout) lockout_seen++;
        exp_v = exp_q.pop_front();
        check("cycle", 32'(dut_vec()), 32'(exp_v));
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b0, 1'b0, !bits[i], bits[i]);
        end
    endtask

    task automatic press_enter();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_relock();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_prog();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        b0     = 1'b0;
        b1     = 1'b0;
        enter  = 1'b0;
        relock = 1'b0;
        prog   = 1'b0;
        model_reset();
        #2;
        check("reset_vec", 32'(dut_vec()), 32'(14'b1_0_0_0000_000_11_0_0));
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Correct unlock with the default code.
        send_bits(8'b1010, 4);
        check("t1_current", 32'(currentOut), 32'(4'b1010));
        check("t1_count", 32'(digitCount), 32'd4);
        press_enter();
        check("t1_locked", 32'(locked), 32'd0);
        check("t1_ok", 32'(ok), 32'd1);
        check("t1_current_clr", 32'(currentOut), 32'd0);
        check("t1_tries", 32'(triesLeft), 32'd3);
        idle();
        check("t1_ok_pulse", 32'(ok), 32'd0);
        press_relock();

        // Incomplete entry, then an overfull one that saturates.
        send_bits(8'b101, 3);
        press_enter();
        check("t2_err", 32'(err), 32'd1);
        check("t2_locked", 32'(locked), 32'd1);
        check("t2_tries", 32'(triesLeft), 32'd2);
        send_bits(8'b101011, 6);
        check("t2_saturate", 32'(currentOut), 32'(4'b1010));
        check("t2_count_sat", 32'(digitCount), 32'd4);
        press_enter();
        check("t2_unlock", 32'(locked), 32'd0);
        check("t2_tries_back", 32'(triesLeft), 32'd3);
        press_relock();

        // Three wrong codes trigger an 8-cycle lockout that ignores input.
        send_bits(8'b0000, 4);
        press_enter();
        send_bits(8'b0000, 4);
        press_enter();
        send_bits(8'b0000, 4);
        lockout_seen = 0;
        press_enter();
        check("t3_lockout", 32'(lockout), 32'd1);
        check("t3_tries0", 32'(triesLeft), 32'd0);
        send_bits(8'b1010, 4);
        press_enter();
        check("t3_still_out", 32'(lockout), 32'd1);
        for (int i = 0; i < 6; i++) idle();
        check("t3_length", 32'(lockout_seen), 32'd8);
        check("t3_lockout_end", 32'(lockout), 32'd0);
        check("t3_locked", 32'(locked), 32'd1);
        check("t3_tries", 32'(triesLeft), 32'd3);

        // Programming abort paths and same-cycle priority.
        send_bits(8'b1010, 4);
        press_enter();
        press_prog();
        check("t5_programming", 32'(programming), 32'd1);
        send_bits(8'b10, 2);
        press_enter();
        check("t5_short_err", 32'(err), 32'd1);
        check("t5_still_prog", 32'(programming), 32'd1);
        send_bits(8'b0000, 4);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_relock_prio", 32'(programming), 32'd0);
        check("t5_relock_locked", 32'(locked), 32'd1);
        check("t5_no_ok", 32'(ok), 32'd0);
        send_bits(8'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_b0_prio", 32'(currentOut), 32'(4'b0010));
        press_relock();
        send_bits(8'b1010, 4);
        press_enter();
        check("t5_old_code", 32'(locked), 32'd0);

        // Reprogram to 0110.
        press_prog();
        send_bits(8'b0110, 4);
        press_enter();
        check("t4_ok", 32'(ok), 32'd1);
        check("t4_locked", 32'(locked), 32'd1);
        check("t4_prog_off", 32'(programming), 32'd0);
        send_bits(8'b1010, 4);
        press_enter();
        check("t4_old_err", 32'(err), 32'd1);
        send_bits(8'b0110, 4);
        press_enter();
        check("t4_new_unlock", 32'(locked), 32'd0);
        press_relock();

        // Async reset in the middle of a lockout.
        for (int k = 0; k < 3; k++) begin
            send_bits(8'b0000, 4);
            press_enter();
        end
        idle();
        idle();
        check("t6_in_lockout", 32'(lockout), 32'd1);
        reset = 1'b1;
        model_reset();
        #2;
        check("t6_reset_vec", 32'(dut_vec()), 32'(14'b1_0_0_0000_000_11_0_0));
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_bits(8'b0110, 4);
        press_enter();
        check("t6_prog_code_gone", 32'(err), 32'd1);
        send_bits(8'b1010, 4);
        press_enter();
        check("t6_default_unlock", 32'(locked), 32'd0);
        check("t6_ok", 32'(ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/code_lock.md
Name: code_lock

Overview:
Parametrised successor to the single-shot binary combination lock. Accepts serial binary digits from debounced button pulses and checks the entered code against a stored code. The stored code is reprogrammable while unlocked. Consecutive wrong attempts are counted, and a configurable number of failures triggers a timed lockout. Sits between the buttonPulse outputs and the board LEDs/pins in the top-level test module.

Parameters:
CODE_SIZE, 8, number of binary digits in a code (width of stored and entered code)
DEFAULT_CODE, 8'b1010_0110, stored code loaded on reset (CODE_SIZE bits)
MAX_TRIES, 3, consecutive wrong enters that trigger lockout (>=1)
LOCKOUT_CYCLES, 1024, clk cycles spent in LOCKOUT (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
b0  input  1  single-cycle pulse: shift in digit 0
b1  input  1  single-cycle pulse: shift in digit 1
enter  input  1  single-cycle pulse: submit entry
relock  input  1  single-cycle pulse: return to LOCKED / abort programming
program  input  1  single-cycle pulse: enter PROGRAM mode (only from UNLOCKED)
locked  output  1  high in every state except UNLOCKED and PROGRAM
lockout  output  1  high while in LOCKOUT
programming  output  1  high while in PROGRAM
currentOut  output  CODE_SIZE  digits entered so far
digitCount  output  $clog2(CODE_SIZE+1)  number of digits entered, saturates at CODE_SIZE
triesLeft  output  $clog2(MAX_TRIES+1)  MAX_TRIES minus failures
ok  output  1  one-cycle pulse: successful unlock or code stored
err  output  1  one-cycle pulse: wrong code or incomplete entry

Behaviour:
- Reset (async, active-high): state=LOCKED, stored=DEFAULT_CODE, current=0, digitCount=0, fails=0, timer=0. Outputs: locked=1, lockout=0, programming=0, currentOut=0, digitCount=0, triesLeft=MAX_TRIES, ok=0, err=0. Reset asserted mid-operation, including mid-PROGRAM or mid-LOCKOUT, discards everything, and the stored code reverts to DEFAULT_CODE.
- All outputs are registered. Every effect appears the cycle after the input pulse.
- One event per cycle. Priority: relock > program > enter > b0 > b1. Lower-priority pulses in the same cycle are dropped.
- Digit entry (LOCKED, UNLOCKED, PROGRAM only):
  - current <= {current[CODE_SIZE-2:0], d}; digitCount++.
  - When digitCount==CODE_SIZE, further digits are ignored (current held, no wrap).
- LOCKED, enter:
  - Match condition: digitCount==CODE_SIZE and current==stored.
  - Match -> UNLOCKED, fails=0, ok pulse.
  - Otherwise -> err pulse, fails++. If the new fails==MAX_TRIES -> LOCKOUT, timer=LOCKOUT_CYCLES-1.
  - Entry (current, digitCount) is cleared in every case.
- LOCKOUT:
  - b0, b1, enter, relock and program are all ignored.
  - timer decrements each cycle. In the cycle timer==0, next state is LOCKED and fails=0.
  - Exactly LOCKOUT_CYCLES cycles are spent with lockout=1.
- UNLOCKED:
  - relock -> LOCKED, entry cleared.
  - program -> PROGRAM, entry cleared.
  - enter -> entry cleared, no other effect.
- PROGRAM:
  - enter with digitCount==CODE_SIZE -> stored<=current, state LOCKED, ok pulse, entry cleared.
  - enter with fewer digits -> err pulse, stay in PROGRAM, entry cleared, stored unchanged.
  - relock -> LOCKED, stored unchanged.
  - program is ignored.
- program in LOCKED or LOCKOUT: ignored. relock in LOCKED: clears the entry only.
- triesLeft = MAX_TRIES - fails at all times. fails never exceeds MAX_TRIES.
- Timer width: $clog2(LOCKOUT_CYCLES), minimum 1 bit.

Decomposition:
- Package lock_pkg: state encodings (LOCKED=0, UNLOCKED=1, PROGRAM=2, LOCKOUT=3), state width constant, and a width helper for counter sizing.
- Sub-module lockout_timer: loadable down-counter with async reset, load value LOCKOUT_CYCLES-1, and a done flag at zero. Instantiated once.
- FSM, shift register, fails counter and stored-code register stay in code_lock.

Test Plan:
Bench parameters for all scenarios: CODE_SIZE=4, DEFAULT_CODE=4'b1010, MAX_TRIES=3, LOCKOUT_CYCLES=8.
1. Correct unlock: pulses b1,b0,b1,b0 then enter -> currentOut=4'b1010 and digitCount=4 before enter; the cycle after enter: locked=0, ok=1 for one cycle, currentOut=0, triesLeft=3.
2. Incomplete and overfull entry: b1,b0,b1 then enter -> err=1, locked=1, triesLeft=2. Then b1,b0,b1,b0,b1,b1 then enter -> currentOut stays 4'b1010 after 4 digits; unlock succeeds, triesLeft=3.
3. Lockout: three wrong enters (code 0000) -> lockout=1 for exactly 8 cycles, during which a correct b1,b0,b1,b0,enter sequence has no effect; then lockout=0, locked=1, triesLeft=3.
4. Reprogram: unlock, program, b0,b1,b1,b0, enter -> ok=1, locked=1, programming=0. Old code 1010 then fails (err=1); new code 0110 unlocks.
5. Abort and priority: in PROGRAM, enter with 2 digits -> err=1, still programming. relock and enter in the same cycle -> LOCKED, stored code unchanged (1010 still unlocks). b0 and b1 in the same cycle -> digit 0 shifted in.
6. Async reset mid-lockout and after reprogram: assert reset between clk edges -> outputs show reset values immediately; DEFAULT_CODE 1010 unlocks again.
